// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, instruction-memory geometry and the
// boot-loader state encoding used by imem_loader and its byte packer.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int IMEM_DEPTH = 128;
  localparam logic [XLEN-1:0] IMEM_BASE = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE
  } loader_state_e;

  // States in which the loader pulls a byte from the stream.
  function automatic logic accepts_bytes(input loader_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian word; word_valid_o fires
// combinationally on the fourth byte so the caller can register the write.
module byte_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            byte_en_i,
  input  logic [7:0]      byte_i,
  output logic            word_valid_o,
  output logic [XLEN-1:0] word_o
);

  logic [1:0]      idx_q, idx_d;
  logic [XLEN-1:0] acc_q, acc_d;

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (clear_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (byte_en_i) begin
      acc_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  assign word_valid_o = byte_en_i && !clear_i && (idx_q == 2'd3);
  assign word_o       = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream (length header + LE words) -> instruction-memory writes,
// holding the core until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int              DEPTH     = IMEM_DEPTH,
  parameter logic [XLEN-1:0] BASE_ADDR = IMEM_BASE,
  parameter int              LEN_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_err,
  output loader_state_e   dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready is a pure decode of the current state, byte_data is don't-care otherwise.

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

  loader_state_e   state_q;
  logic [LEN_W-1:0] word_count_q, word_idx_q, word_idx_nxt, hdr_count;
  logic            imem_we_q, cpu_hold_q, load_done_q, load_err_q;
  logic [XLEN-1:0] imem_addr_q, imem_wdata_q;
  logic            xfer, data_xfer, start_ok, word_valid, idx_in_range;
  logic [XLEN-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  assign byte_ready   = accepts_bytes(state_q);
  assign xfer         = byte_valid && byte_ready;
  assign data_xfer    = xfer && (state_q == DATA);
  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
  assign hdr_count    = LEN_W'({byte_data, word_count_q[7:0]});
  assign word_idx_nxt = word_idx_q + LEN_W'(1);
  assign idx_in_range = ({1'b0, word_idx_q} < DEPTH_L);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .byte_en_i    (data_xfer),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && (state_q != CSUM)) csum_q <= csum_q ^ byte_data;
`endif
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q      <= LEN_LO;
            word_count_q <= '0;
            word_idx_q   <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end else if ((state_q == DONE) && !load_done_q) begin
            // Entered from DATA: release one cycle after the final write pulse.
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            word_count_q <= LEN_W'(byte_data);
            state_q      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            word_count_q <= hdr_count;
            if ({1'b0, hdr_count} > DEPTH_L) load_err_q <= 1'b1;
            if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= CSUM;
`else
              state_q     <= DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
`endif
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (data_xfer && word_valid) begin
            // Oversized images are drained so the stream stays aligned, but never written.
            if (idx_in_range) begin
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word;
              imem_addr_q  <= BASE_ADDR + XLEN'({word_idx_q, 2'b00});
            end
            word_idx_q <= word_idx_nxt;
            if (word_idx_nxt == word_count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= CSUM;
`else
              state_q <= DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            state_q     <= DONE;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
            if (byte_data != csum_q) load_err_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign dbg_state  = state_q;

endmodule
